// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and queue entry type for the register file write queue
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular-buffer FIFO of writeback entries with a per-slot valid view
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head_entry,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output wb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  wb_entry_t        mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_entry;
  end

  assign head_entry = mem[head];

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = mem[i];
      valid[i]   = (CNT_W'(PTR_W'(PTR_W'(i) - head)) < count);
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - buffers writebacks and drains them onto the register file write port
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [REG_DATA_W-1:0] wb_data,
  input  logic                  hold,
  output logic [REG_ADDR_W-1:0] A3,
  output logic                  WE3,
  output logic [REG_DATA_W-1:0] WD3,
  input  logic [REG_ADDR_W-1:0] A1,
  input  logic [REG_ADDR_W-1:0] A2,
  output logic                  pend1,
  output logic                  pend2,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full
);

  wb_entry_t        head_entry;
  wb_entry_t        push_entry;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             drain;

  assign push_entry = '{addr: wb_addr, data: wb_data};
  assign drain      = ~empty & ~hold;

  wb_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (CLK),
    .rst        (RESET),
    .push       (wb_valid),
    .push_entry (push_entry),
    .pop        (drain),
    .head_entry (head_entry),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .entries    (entries),
    .valid      (valid)
  );

  // No bypass when full: a same-cycle drain does not open a slot early.
  assign wb_ready = ~full;
  assign WE3      = drain;
  assign A3       = empty ? '0 : head_entry.addr;
  assign WD3      = empty ? '0 : head_entry.data;

  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].addr == A1)) pend1 = 1'b1;
      if (valid[i] && (entries[i].addr == A2)) pend2 = 1'b1;
    end
  end

endmodule
